// File: rtl/cnn_pkg.sv
// Shared defaults and width helper for the convolution datapath blocks.
package cnn_pkg;

  localparam int DEF_DATA_W       = 39;
  localparam int DEF_IMAGE_WIDTH  = 28;
  localparam int DEF_KERNEL_WIDTH = 5;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_delay_if.sv
// Sample stream interface for line_delay; fill_level exists only with LINE_DELAY_LEVEL_EN.
interface line_delay_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_IMAGE_WIDTH - DEF_KERNEL_WIDTH
);
  localparam int FILL_W = cnt_width(DEPTH + 1);

  logic signed [DATA_W-1:0] data_in;
  logic                     in_valid;
  logic                     clear;
  logic signed [DATA_W-1:0] data_out;
  logic                     out_valid;
  logic                     primed;
`ifdef LINE_DELAY_LEVEL_EN
  logic [FILL_W-1:0]        fill_level;

  modport master (output data_in, in_valid, clear,
                  input  data_out, out_valid, primed, fill_level);
  modport slave  (input  data_in, in_valid, clear,
                  output data_out, out_valid, primed, fill_level);
`else
  modport master (output data_in, in_valid, clear,
                  input  data_out, out_valid, primed);
  modport slave  (input  data_in, in_valid, clear,
                  output data_out, out_valid, primed);
`endif

endinterface

// File: rtl/delay_ram.sv
// DEPTH x DATA_W circular storage: combinational read, synchronous write, no reset.
module delay_ram #(
  parameter int DATA_W = 39,
  parameter int DEPTH  = 23,
  parameter int PTR_W  = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  ptr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rd_data = mem[ptr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/line_delay.sv
// Valid-gated line delay: each accepted sample re-emerges DEPTH accepted beats later.
// Optional fill_level output enabled by defining LINE_DELAY_LEVEL_EN.
module line_delay
  import cnn_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH,
  parameter int DEPTH        = IMAGE_WIDTH - KERNEL_WIDTH
) (
  input logic        clk,
  input logic        reset,
  line_delay_if.slave bus
);

  localparam int PTR_W  = cnt_width(DEPTH);
  localparam int FILL_W = cnt_width(DEPTH + 1);

  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W-1:0]  ptr_next;
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_next;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              accept;

  assign full   = (fill_reg == FILL_W'(DEPTH));
  // clear takes priority, so a beat coinciding with it is never written.
  assign accept = bus.in_valid & ~bus.clear;

  always_comb begin
    ptr_next  = (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + PTR_W'(1);
    fill_next = full ? fill_reg : fill_reg + FILL_W'(1);
  end

  delay_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we      (accept),
    .ptr     (ptr_reg),
    .wr_data (bus.data_in),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg       <= '0;
      fill_reg      <= '0;
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
    end else if (bus.clear) begin
      ptr_reg       <= '0;
      fill_reg      <= '0;
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      ptr_reg       <= ptr_next;
      fill_reg      <= fill_next;
      bus.data_out  <= full ? $signed(rd_data) : '0;
      bus.out_valid <= full;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

  assign bus.primed = full;
`ifdef LINE_DELAY_LEVEL_EN
  assign bus.fill_level = fill_reg;
`endif

endmodule

// File: tb/tb_line_delay.sv
// Randomised self-checking bench for line_delay against a queue-based reference model.
module tb_line_delay;
  localparam int DW  = 39;
  localparam int D23 = 23;
  localparam int D4  = 4;

  logic clk;
  logic reset;

  line_delay_if #(.DATA_W(DW), .DEPTH(D23)) bus23 ();
  line_delay_if #(.DATA_W(DW), .DEPTH(D4))  bus4 ();

  line_delay #(.DATA_W(DW), .DEPTH(D23)) dut23 (.clk(clk), .reset(reset), .bus(bus23));
  line_delay #(.DATA_W(DW), .DEPTH(D4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  logic signed [DW-1:0] q[$];
  logic signed [DW-1:0] exp_data;
  logic                 exp_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("data_out", bus23.data_out, exp_data);
    check("out_valid", bus23.out_valid, exp_valid);
    check("primed", bus23.primed, q.size() == D23);
`ifdef LINE_DELAY_LEVEL_EN
    check("fill_level", bus23.fill_level, q.size());
`endif
  endtask

  // One clock on the DEPTH=23 instance, model updated from the behavioural rules.
  task automatic cycle(input logic v, input logic c, input logic signed [DW-1:0] d);
    bus23.in_valid = v;
    bus23.clear    = c;
    bus23.data_in  = d;
    @(posedge clk);
    if (c) begin
      q.delete();
      exp_data  = '0;
      exp_valid = 1'b0;
    end else if (v) begin
      q.push_back(d);
      if (q.size() > D23) begin
        exp_data  = q.pop_front();
        exp_valid = 1'b1;
      end else begin
        exp_data  = '0;
        exp_valid = 1'b0;
      end
    end else begin
      exp_valid = 1'b0;
    end
    #1;
    $display("t=%0t v=%0b c=%0b din=%0d dout=%0d ov=%0b primed=%0b",
             $time, v, c, d, bus23.data_out, bus23.out_valid, bus23.primed);
    check_outputs();
  endtask

  logic signed [DW-1:0] vals4 [5];
  logic signed [DW-1:0] d;
  int cnt;

  initial begin
    reset = 1'b0;
    bus23.in_valid = 1'b0; bus23.clear = 1'b0; bus23.data_in = '0;
    bus4.in_valid  = 1'b0; bus4.clear  = 1'b0; bus4.data_in  = '0;
    exp_data = '0; exp_valid = 1'b0;

    #2 reset = 1'b1;
    #1;
    check_outputs();
    @(negedge clk) reset = 1'b0;

    // Continuous stream 1..60.
    for (int i = 1; i <= 60; i++) begin
      cycle(1'b1, 1'b0, DW'(i));
      if (i == 24) check("first_out", bus23.data_out, 1);
    end

    // Clear together with a valid beat: the beat must be dropped.
    cycle(1'b1, 1'b1, DW'(999));
    for (int i = 1; i <= 30; i++) cycle(1'b1, 1'b0, DW'(1000 + i));

    // Stall every third cycle.
    cycle(1'b0, 1'b1, '0);
    cnt = 1;
    for (int i = 0; i < 90; i++) begin
      if (i % 3 == 2) cycle(1'b0, 1'b0, DW'(77));
      else begin
        cycle(1'b1, 1'b0, DW'(cnt));
        cnt++;
      end
    end

    // Random valid/clear pattern with random signed data.
    for (int i = 0; i < 400; i++) begin
      d = DW'({$urandom, $urandom});
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, d);
    end

    // Prime, then pulse the asynchronous reset between edges.
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0, DW'({$urandom, $urandom}));
    check("primed_before_reset", bus23.primed, 1);
    bus23.in_valid = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    q.delete();
    exp_data = '0;
    exp_valid = 1'b0;
    #1;
    check_outputs();
    #2 reset = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      cycle(1'b1, 1'b0, DW'(5000 + i));
      if (i == 22) check("reprime_22", bus23.primed, 0);
      if (i == 23) check("reprime_23", bus23.primed, 1);
    end
    cycle(1'b0, 1'b0, '0);

    // DEPTH=4 wrap and sign extension.
    vals4[0] = -39'sd5; vals4[1] = 39'sd7; vals4[2] = -39'sd1;
    vals4[3] = 39'sd3;  vals4[4] = -39'sd8;
    for (int i = 0; i < 5; i++) begin
      bus4.in_valid = 1'b1;
      bus4.data_in  = vals4[i];
      @(posedge clk);
      #1;
      $display("t=%0t d4 beat=%0d din=%0d dout=%0d ov=%0b primed=%0b",
               $time, i + 1, vals4[i], bus4.data_out, bus4.out_valid, bus4.primed);
      if (i == 3) begin
        check("d4_ov_beat4", bus4.out_valid, 0);
        check("d4_primed_beat4", bus4.primed, 1);
      end
    end
    bus4.in_valid = 1'b0;
    check("d4_data_beat5", bus4.data_out, vals4[0]);
    check("d4_ov_beat5", bus4.out_valid, 1);
    check("d4_ptr", dut4.ptr_reg, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule

// File: doc/line_delay.md
# line_delay

Parametrised, valid-gated line delay for the convolution datapath. It holds the last DEPTH accepted samples in a circular buffer and emits each sample exactly DEPTH accepted beats after it entered. Shifting only happens on accepted beats, so the pipeline tolerates stalls. It supports any data width and row geometry, reports when the window is primed, and can be flushed without a reset.

## Interface
Parameters:
- DATA_W, 39: sample width in bits (signed two's complement).
- IMAGE_WIDTH, 28: image row length in samples.
- KERNEL_WIDTH, 5: convolution kernel width.
- DEPTH, IMAGE_WIDTH-KERNEL_WIDTH (23): delay in accepted beats. Legal range is ≥ 2.

Ports:
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- data_in, input, DATA_W (signed): input sample.
- in_valid, input, 1: data_in is accepted on this edge.
- clear, input, 1: synchronous flush.
- data_out, output, DATA_W (signed): delayed sample (registered).
- out_valid, output, 1: data_out holds a new, valid delayed sample.
- primed, output, 1: the buffer holds DEPTH valid samples.
- fill_level, output, $clog2(DEPTH+1): number of valid samples held. Present only with LINE_DELAY_LEVEL_EN.

## Operation
- Storage is a DEPTH×DATA_W array with no reset. A write pointer `ptr` runs 0..DEPTH-1. A fill counter `fill` saturates at DEPTH.
- Accepted beat (in_valid=1, clear=0, reset=0):
  - Read mem[ptr] (old content), then write mem[ptr] ← data_in.
  - ptr ← (ptr==DEPTH-1) ? 0 : ptr+1.
  - fill ← min(fill+1, DEPTH).
  - If fill==DEPTH before the edge: data_out ← old mem[ptr] and out_valid ← 1.
  - Otherwise: data_out ← 0 and out_valid ← 0.
- No beat (in_valid=0): ptr, fill, mem and data_out hold; out_valid ← 0.
- primed = (fill==DEPTH), driven from the register.
- clear=1: ptr←0, fill←0, data_out←0, out_valid←0. Mem content is left stale; it is never emitted because of the fill gating.
- clear and in_valid in the same cycle: clear wins and the beat is dropped, not written.
- Reset (async, at any time, including mid-row): same state as clear. Sampling resumes on the first edge after deassertion.
- Reset values: data_out=0, out_valid=0, primed=0, fill_level=0.
- Values pass through unmodified; there is no arithmetic on data. Pointer and fill widths are $clog2(DEPTH) and $clog2(DEPTH+1).

## Timing
- Latency: data_out after accepted beat k equals data_in of accepted beat k−DEPTH. This is counted in accepted beats, not clocks.
- First out_valid occurs on accepted beat number DEPTH+1 after reset or clear (beats indexed from 1).
- Throughput is one sample per clock with no bubbles. in_valid may toggle arbitrarily.
- Pointer wrap is seamless: the beat at ptr=DEPTH-1 is followed by ptr=0 with no gap.
- out_valid is a one-cycle pulse per accepted beat once primed.
- There is no output backpressure; the downstream block must consume every out_valid.

## Configuration
- LINE_DELAY_LEVEL_EN defined: the fill_level port exists and equals `fill`. It is registered and updates on the same edges as fill.
- Not defined: the port is absent and the fill counter stays internal. primed and all other behaviour are identical.

## Structure
- Shared package cnn_pkg holds:
  - the IMAGE_WIDTH and KERNEL_WIDTH defaults;
  - the default DATA_W (39);
  - a width helper function for the pointer and fill widths.
- Sub-module delay_ram:
  - DEPTH×DATA_W array;
  - combinational read at ptr;
  - synchronous write enable;
  - no reset.
- The top level owns ptr, fill, clear/reset priority, and the data_out/out_valid registers.

## Test plan
- Reset then stream: DEPTH=23, DATA_W=39, in_valid held high, data_in = beat index 1..60. Required: out_valid first rises after beat 24 with data_out=1, then data_out increments by 1 per clock. primed=1 from beat 23 onward.
- Stalls: same stream with in_valid low on every third cycle. Required: output sequence 1,2,3,… with no skips or repeats, and out_valid=0 on every stalled cycle.
- Wrap and sign: DEPTH=4 with inputs −5,7,−1,3,−8 (signed). Required: data_out=−5 (all ones in the upper bits) after beat 5, and ptr back at 1.
- Clear mid-stream: clear asserted together with in_valid after beat 30 (DEPTH=23). Required: that beat is dropped; out_valid=0 and primed=0 next cycle. The next valid output is the first post-clear sample, after 24 further beats.
- Async reset mid-operation: reset pulsed between clock edges while primed. Required: data_out=0, out_valid=0 and primed=0 immediately, without waiting for a clock edge. Re-priming takes 23 beats.
- LINE_DELAY_LEVEL_EN: fill_level reads 0,1,…,23 over the first 23 beats and then saturates at 23. Without the macro, the build elaborates without the port.
